// File: rtl/tlc_phase_ctrl.sv
// Two-road traffic-light phase controller with tick-enabled phase timers and all-red clearance.
// Optional pedestrian walk phase is compiled in when the TLC_PED_EN macro is defined.
module tlc_phase_ctrl #(
  parameter int CNT_W        = 6,
  parameter int NS_GREEN_MIN = 32,
  parameter int EW_GREEN_MIN = 16,
  parameter int YELLOW_T     = 4,
  parameter int ALLRED_T     = 2,
  parameter int PED_T        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_ns_detect,
  input  logic             i_ew_detect,
  input  logic             i_ped_req,
  output logic             o_ns_red,
  output logic             o_ns_yellow,
  output logic             o_ns_green,
  output logic             o_ew_red,
  output logic             o_ew_yellow,
  output logic             o_ew_green,
  output logic             o_walk,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_phase_cnt
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (NS_GREEN_MIN < 1 || NS_GREEN_MIN > CNT_MAX) begin : g_bad_ns_green
    $error("tlc_phase_ctrl: NS_GREEN_MIN out of range");
  end
  if (EW_GREEN_MIN < 1 || EW_GREEN_MIN > CNT_MAX) begin : g_bad_ew_green
    $error("tlc_phase_ctrl: EW_GREEN_MIN out of range");
  end
  if (YELLOW_T < 1 || YELLOW_T > CNT_MAX) begin : g_bad_yellow
    $error("tlc_phase_ctrl: YELLOW_T out of range");
  end
  if (ALLRED_T < 1 || ALLRED_T > CNT_MAX) begin : g_bad_allred
    $error("tlc_phase_ctrl: ALLRED_T out of range");
  end
  if (PED_T < 1 || PED_T > CNT_MAX) begin : g_bad_ped
    $error("tlc_phase_ctrl: PED_T out of range");
  end

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_EW = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_NS = 3'd5,
    WALK  = 3'd6
  } state_e;

  // Last counter value of each timed state; the exit happens on the tick seen at this value.
  localparam logic [CNT_W-1:0] NS_GREEN_LAST = CNT_W'(NS_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] EW_GREEN_LAST = CNT_W'(EW_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST   = CNT_W'(ALLRED_T - 1);
`ifdef TLC_PED_EN
  localparam logic [CNT_W-1:0] PED_LAST      = CNT_W'(PED_T - 1);
`endif

  // Lamp vector order: {walk, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}.
  function automatic logic [6:0] lamp_decode(input state_e s);
    case (s)
      NS_G:    lamp_decode = 7'b0_001_100;
      NS_Y:    lamp_decode = 7'b0_010_100;
      EW_G:    lamp_decode = 7'b0_100_001;
      EW_Y:    lamp_decode = 7'b0_100_010;
      WALK:    lamp_decode = 7'b1_100_100;
      default: lamp_decode = 7'b0_100_100;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       lamp_q, lamp_d;
`ifdef TLC_PED_EN
  logic             ped_q, ped_d;
  logic             dir_ew_q, dir_ew_d;
`else
  logic             unused_ped_req;
  assign unused_ped_req = i_ped_req;
`endif

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
`ifdef TLC_PED_EN
    ped_d    = ped_q | i_ped_req;
    dir_ew_d = dir_ew_q;
`endif
    case (state_q)
      NS_G:  if (i_tick && i_ew_detect && cnt_q >= NS_GREEN_LAST) state_d = NS_Y;
      NS_Y:  if (i_tick && cnt_q == YELLOW_LAST)                  state_d = AR_EW;
      EW_G:  if (i_tick && i_ns_detect && cnt_q >= EW_GREEN_LAST) state_d = EW_Y;
      EW_Y:  if (i_tick && cnt_q == YELLOW_LAST)                  state_d = AR_NS;
      AR_EW: if (i_tick && cnt_q == ALLRED_LAST) begin
`ifdef TLC_PED_EN
        if (ped_q) begin
          state_d  = WALK;
          dir_ew_d = 1'b1;
        end else begin
          state_d  = EW_G;
        end
`else
        state_d = EW_G;
`endif
      end
      AR_NS: if (i_tick && cnt_q == ALLRED_LAST) begin
`ifdef TLC_PED_EN
        if (ped_q) begin
          state_d  = WALK;
          dir_ew_d = 1'b0;
        end else begin
          state_d  = NS_G;
        end
`else
        state_d = NS_G;
`endif
      end
`ifdef TLC_PED_EN
      WALK:  if (i_tick && cnt_q == PED_LAST) begin
        state_d = dir_ew_q ? EW_G : NS_G;
        // A request arriving in the exit cycle keeps the latch set for the next all-red.
        ped_d   = i_ped_req;
      end
`endif
      default: state_d = NS_G;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (i_tick && cnt_q != CNT_W'(CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    lamp_d = lamp_decode(state_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= NS_G;
      cnt_q    <= '0;
      lamp_q   <= lamp_decode(NS_G);
`ifdef TLC_PED_EN
      ped_q    <= 1'b0;
      dir_ew_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lamp_q   <= lamp_d;
`ifdef TLC_PED_EN
      ped_q    <= ped_d;
      dir_ew_q <= dir_ew_d;
`endif
    end
  end

  assign o_walk      = lamp_q[6];
  assign o_ns_red    = lamp_q[5];
  assign o_ns_yellow = lamp_q[4];
  assign o_ns_green  = lamp_q[3];
  assign o_ew_red    = lamp_q[2];
  assign o_ew_yellow = lamp_q[1];
  assign o_ew_green  = lamp_q[0];
  assign o_state     = state_q;
  assign o_phase_cnt = cnt_q;

endmodule

// File: doc/tlc_phase_ctrl.md
# tlc_phase_ctrl

Parametrised, fully synchronous two-road traffic-light phase controller with integrated phase timers. Next-generation replacement for the NS/EW light controller and its ripple counters. Adds configurable green/yellow/all-red durations, a tick-enable timebase, all-red clearance and an optional pedestrian walk phase. Sits between the prescaler tick generator and the lamp drivers.

## Interface
- CNT_W, 6: phase counter width in bits.
- NS_GREEN_MIN, 32: minimum NS green duration, in ticks.
- EW_GREEN_MIN, 16: minimum EW green duration, in ticks.
- YELLOW_T, 4: yellow duration, in ticks, both roads.
- ALLRED_T, 2: all-red clearance duration, in ticks.
- PED_T, 8: walk duration, in ticks. Used only with TLC_PED_EN.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  timebase enable; timers advance only in cycles where it is 1.
- i_ns_detect  in  1  NS vehicle demand (level).
- i_ew_detect  in  1  EW vehicle demand (level).
- i_ped_req  in  1  pedestrian request (pulse or level).
- o_ns_red, o_ns_yellow, o_ns_green  out  1 each  NS lamps.
- o_ew_red, o_ew_yellow, o_ew_green  out  1 each  EW lamps.
- o_walk  out  1  pedestrian walk lamp.
- o_state  out  3  current state encoding.
- o_phase_cnt  out  CNT_W  ticks elapsed in the current state.

## Operation
- States and encodings: NS_G=0, NS_Y=1, AR_EW=2, EW_G=3, EW_Y=4, AR_NS=5, WALK=6. Encoding 7 is illegal and recovers to NS_G on the next clock.
- Lamps are a Moore decode of the state:
  - NS_G: NS green, EW red.
  - NS_Y: NS yellow, EW red.
  - EW_G: EW green, NS red.
  - EW_Y: EW yellow, NS red.
  - AR_EW, AR_NS, WALK: both roads red. o_walk=1 only in WALK.
- Exactly one lamp per road is on at all times.
- Phase counter:
  - Cleared to 0 on every state change.
  - Otherwise increments on each i_tick=1 cycle.
  - Saturates at 2^CNT_W-1.
- A timed state of T ticks exits on the tick cycle where o_phase_cnt==T-1.
- NS_G→NS_Y: on a tick cycle where o_phase_cnt≥NS_GREEN_MIN-1 and i_ew_detect=1. With no EW demand, NS green holds indefinitely.
- EW_G→EW_Y: same rule, using EW_GREEN_MIN and i_ns_detect.
- NS_Y→AR_EW after YELLOW_T ticks. EW_Y→AR_NS after YELLOW_T ticks.
- AR_EW→EW_G and AR_NS→NS_G after ALLRED_T ticks, unless the walk phase is taken (see Configuration).
- Demand inputs are sampled only on qualifying tick cycles. Demand that drops before the minimum green has elapsed is ignored.
- Parameter legality: every duration is ≥1 and ≤2^CNT_W-1. Violations are reported with an elaboration-time $error.
- Reset (asserted at any time, including mid-phase):
  - State=NS_G, o_phase_cnt=0, pedestrian latch=0.
  - Lamps: o_ns_green=1, o_ew_red=1, all other lamps 0, o_walk=0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- A qualifying tick in cycle N gives the new state and lamps visible from cycle N+1.
- With i_tick tied high, each duration in ticks equals the duration in clock cycles.
- With i_tick low, state and counter freeze. Demand inputs are not observed.
- Reset assertion takes effect immediately, with no clock needed. Deassertion is synchronised externally. The first count occurs on the first tick after release.

## Configuration
- Macro: TLC_PED_EN.
- Defined:
  - i_ped_req=1 in any cycle sets a sticky pedestrian latch.
  - When AR_EW or AR_NS completes with the latch set, the next state is WALK instead of the green state.
  - WALK lasts PED_T ticks, then enters the green the all-red was heading to (direction held in a 1-bit register). The latch clears on WALK exit.
  - If a request and the latch clear occur in the same cycle, the request wins and the latch stays set.
- Not defined:
  - No latch and no WALK state. State 6 is treated as illegal.
  - o_walk is tied 0. i_ped_req is ignored. PED_T is unused.
  - Port list is unchanged.

## Test plan
- Reset, i_tick=1, i_ew_detect=1, i_ns_detect=0 → NS green for cycles 0–31, NS yellow for cycles 32–35, all red for cycles 36–37, EW green from cycle 38 held indefinitely; o_phase_cnt saturates at 63.
- Both detects 0 for 1000 cycles → NS green throughout, o_phase_cnt=63 from cycle 63.
- i_ew_detect rises at cycle 100 with i_tick=1 → NS yellow first visible at cycle 101, o_phase_cnt=0 there.
- i_tick=1 every 4th cycle, i_ew_detect=1 → NS green lasts 128 cycles, yellow 16 cycles, all-red 8 cycles.
- TLC_PED_EN defined, i_ped_req pulsed 1 cycle during NS green, i_ew_detect=1 → after AR_EW, 8 cycles of WALK with o_walk=1 and both roads red, then EW green and latch=0. With the macro undefined, the same stimulus gives no WALK state and o_walk=0.
- i_rst_n asserted in the 2nd cycle of EW_Y → in the same cycle, state=0, o_ns_green=1, o_ew_red=1, o_phase_cnt=0.
